// File: rtl/fp_add_pipe_if.sv
// Valid/ready operand and result channel of the single-precision FP adder.
// slave is the adder's view, master is the producer/consumer view.
interface fp_add_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  modport slave (
    input  in_valid, op_sub, A, B, out_ready,
    output in_ready, out_valid, result
  );

  modport master (
    output in_valid, op_sub, A, B, out_ready,
    input  in_ready, out_valid, result
  );
endinterface

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE 754 single-precision add/subtract, flush-to-zero, whole-pipe stall.
// Define FP_ADD_RNE_EN for round-to-nearest-even with overflow to Inf; default truncates and saturates.
module fp_add_pipe #(
  parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
  input  logic         clk,
  input  logic         reset,
  fp_add_pipe_if.slave bus
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic round_inc(input logic lsb, input logic [2:0] grs);
`ifdef FP_ADD_RNE_EN
    return grs[2] & (grs[1] | grs[0] | lsb);
`else
    // Truncation discards guard/round/sticky entirely.
    return 1'b0 & |{lsb, grs};
`endif
  endfunction

  function automatic logic [31:0] pack_sat(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] m);
    if (e >= 10'sd255) begin
`ifdef FP_ADD_RNE_EN
      return {s, 8'hFF, 23'h000000};
`else
      return {s, 8'hFE, 23'h7FFFFF};
`endif
    end else if (e <= 10'sd0) begin
      return {s, 31'h0};
    end else begin
      return {s, e[7:0], m};
    end
  endfunction

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // S1: unpack, swap, align, classify specials
  logic        a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [7:0]  a_exp, b_exp, x_exp, y_exp, d;
  logic [22:0] a_man, b_man;
  logic [23:0] a_full, b_full, x_man, y_man;
  logic [30:0] a_mag, b_mag;
  logic        x_sign, y_sign, force_s;
  logic [49:0] y_wide;
  logic [26:0] y_al;
  logic [31:0] forced_s;

  always_comb begin
    a_sign = bus.A[31];
    b_sign = bus.B[31] ^ bus.op_sub;
    a_exp  = bus.A[30:23];
    b_exp  = bus.B[30:23];
    a_man  = bus.A[22:0];
    b_man  = bus.B[22:0];
    a_zero = (a_exp == 8'h00);
    b_zero = (b_exp == 8'h00);
    a_inf  = (a_exp == 8'hFF) && (a_man == 23'h0);
    b_inf  = (b_exp == 8'hFF) && (b_man == 23'h0);
    a_nan  = (a_exp == 8'hFF) && (a_man != 23'h0);
    b_nan  = (b_exp == 8'hFF) && (b_man != 23'h0);
    a_mag  = a_zero ? 31'h0 : bus.A[30:0];
    b_mag  = b_zero ? 31'h0 : bus.B[30:0];
    a_full = a_zero ? 24'h0 : {1'b1, a_man};
    b_full = b_zero ? 24'h0 : {1'b1, b_man};
    swap   = (b_mag > a_mag);
    x_sign = swap ? b_sign : a_sign;
    y_sign = swap ? a_sign : b_sign;
    x_exp  = swap ? b_exp  : a_exp;
    y_exp  = swap ? a_exp  : b_exp;
    x_man  = swap ? b_full : a_full;
    y_man  = swap ? a_full : b_full;
    d      = x_exp - y_exp;
    y_wide = {y_man, 26'h0} >> d;
    y_al   = (d >= 8'd26) ? {26'h0, |y_man} : {y_wide[49:24], |y_wide[23:0]};

    force_s  = 1'b1;
    forced_s = NAN_CANON;
    if (a_nan || b_nan) begin
      forced_s = NAN_CANON;
    end else if (a_inf && b_inf) begin
      forced_s = (a_sign != b_sign) ? NAN_CANON : {a_sign, 8'hFF, 23'h0};
    end else if (a_inf) begin
      forced_s = {a_sign, 8'hFF, 23'h0};
    end else if (b_inf) begin
      forced_s = {b_sign, 8'hFF, 23'h0};
    end else if (a_zero && b_zero) begin
      forced_s = {a_sign & b_sign, 31'h0};
    end else begin
      force_s = 1'b0;
    end
  end

  logic        vld_p0, sx_p0, sy_p0, force_p0;
  logic [7:0]  ex_p0;
  logic [23:0] xman_p0;
  logic [26:0] yal_p0;
  logic [31:0] forced_p0;

  // S2: magnitude add/subtract
  logic [27:0] sum_s;
  always_comb begin
    if (sx_p0 ^ sy_p0) sum_s = {1'b0, xman_p0, 3'b000} - {1'b0, yal_p0};
    else               sum_s = {1'b0, xman_p0, 3'b000} + {1'b0, yal_p0};
  end

  logic        vld_p1, sign_p1, force_p1;
  logic [7:0]  exp_p1;
  logic [27:0] sum_p1;
  logic [31:0] forced_p1;

  // S3: normalize, round, pack
  logic [4:0]         lz;
  logic [26:0]        norm;
  logic signed [9:0]  e;
  logic               inc;
  logic [24:0]        m25;
  logic [22:0]        mant;
  logic [31:0]        res_s;

  always_comb begin
    lz = lzc27(sum_p1[26:0]);
    if (sum_p1[27]) begin
      norm = {sum_p1[27:2], sum_p1[1] | sum_p1[0]};
      e    = signed'({2'b00, exp_p1}) + 10'sd1;
    end else begin
      norm = sum_p1[26:0] << lz;
      e    = signed'({2'b00, exp_p1}) - signed'({5'b00000, lz});
    end
    inc = round_inc(norm[3], norm[2:0]);
    m25 = {1'b0, norm[26:3]} + {24'h0, inc};
    if (m25[24]) begin
      mant = m25[23:1];
      e    = e + 10'sd1;
    end else begin
      mant = m25[22:0];
    end
    if (force_p1)             res_s = forced_p1;
    else if (sum_p1 == 28'h0) res_s = 32'h0;
    else                      res_s = pack_sat(sign_p1, e, mant);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.result    <= 32'h0;
    end else if (adv) begin
      vld_p0        <= bus.in_valid;
      vld_p1        <= vld_p0;
      bus.out_valid <= vld_p1;
      bus.result    <= vld_p1 ? res_s : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sx_p0     <= x_sign;
      sy_p0     <= y_sign;
      ex_p0     <= x_exp;
      xman_p0   <= x_man;
      yal_p0    <= y_al;
      force_p0  <= force_s;
      forced_p0 <= forced_s;
      sign_p1   <= sx_p0;
      exp_p1    <= ex_p0;
      sum_p1    <= sum_s;
      force_p1  <= force_p0;
      forced_p1 <= forced_p0;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: latency, streaming, specials, rounding, backpressure, reset.
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fp_add_pipe_if bus ();
  fp_add_pipe dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic [31:0] se [8];
  logic        ss [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.op_sub   = sub;
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] expv, input string tag);
    @(negedge clk);
    drive(a, b, sub);
    chk({tag, "_in_ready"}, {31'h0, bus.in_ready}, 32'h1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, {31'h0, bus.out_valid}, 32'h0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'h0, bus.out_valid}, 32'h1);
    chk(tag, bus.result, expv);
  endtask

  initial begin
    sa = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40A00000,
           32'h3F800000, 32'h41200000, 32'h3F000000, 32'hC0000000};
    sb = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000,
           32'h40000000, 32'h40A00000, 32'h3E800000, 32'h3F800000};
    ss = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    se = '{32'h40000000, 32'h40800000, 32'h40800000, 32'h40800000,
           32'hBF800000, 32'h41700000, 32'h3F400000, 32'hBF800000};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = 32'h0;
    bus.B         = 32'h0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_result", bus.result, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);

    run_one(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, "add_1_2");

    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 3 && c < 11) begin
        chk("stream_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("stream_result", bus.result, se[c-3]);
      end
      if (c == 11) chk("stream_drain", {31'h0, bus.out_valid}, 32'h0);
      if (c < 8) drive(sa[c], sb[c], ss[c]);
      else bus.in_valid = 1'b0;
    end

    run_one(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, "cancel");
    run_one(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, "neg_zeros");
    run_one(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, "inf_minus_inf");
    run_one(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, "nan_in");
    run_one(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, "inf_plus_one");
`ifdef FP_ADD_RNE_EN
    run_one(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, "round_up");
    run_one(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, "overflow");
`else
    run_one(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, "round_trunc");
    run_one(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, "overflow");
`endif
    run_one(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, "round_tie");

    // Backpressure: stall as soon as the first result appears.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(sa[c], sb[c], ss[c]);
    end
    @(negedge clk);
    chk("bp_first_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("bp_first_result", bus.result, se[0]);
    drive(sa[3], sb[3], ss[3]);
    bus.out_ready = 1'b0;
    #1;
    chk("bp_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("bp_hold_result", bus.result, se[0]);
      chk("bp_hold_in_ready", {31'h0, bus.in_ready}, 32'h0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", {31'h0, bus.in_ready}, 32'h1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_drain_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("bp_drain_result", bus.result, se[k]);
    end
    @(negedge clk);
    chk("bp_empty", {31'h0, bus.out_valid}, 32'h0);

    // Reset with three operations in flight.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(sa[c], sb[c], ss[c]);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", {31'h0, bus.out_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("async_rst_result", bus.result, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_stale", {31'h0, bus.out_valid}, 32'h0);
    end
    run_one(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, "post_rst_add");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
